// File: rtl/hyperbus_target.sv
// HyperBus follower: decodes the 48-bit CA, waits out the initial latency and serves linear
// bursts from a synchronous SRAM back-end. Define HBUS_TARGET_REGS_EN for the ID/CR register space.
module hyperbus_target #(
    parameter int          WIDTH         = 8,
    parameter int          ADDR_LENGTH   = 32,
    parameter int          LATENCY_COUNT = 6,
    parameter logic [15:0] ID0_VALUE     = 16'h0c81,
    parameter logic [15:0] ID1_VALUE     = 16'h0001,
    parameter logic [15:0] CR0_RESET     = 16'h8f1f
) (
    input  logic                   clk90,
    input  logic                   rst,
    input  logic                   ck_en,
    input  logic                   csn,
    input  logic [2*WIDTH-1:0]     dq_in,
    input  logic [1:0]             rwds_in,
    output logic [2*WIDTH-1:0]     dq_out,
    output logic                   dq_oe,
    output logic [1:0]             rwds_out,
    output logic                   rwds_oe,
    output logic [ADDR_LENGTH-1:0] mem_adr,
    output logic                   mem_re,
    input  logic [2*WIDTH-1:0]     mem_rdat,
    output logic                   mem_we,
    output logic [1:0]             mem_be,
    output logic [2*WIDTH-1:0]     mem_wdat
);

    // state   | meaning
    // IDLE    | bus deselected; first CA word taken when csn low
    // CA      | collecting CA words 1 and 2, decode on word 2
    // LATENCY | initial latency countdown; last cycle issues first read
    // READ    | drive read words, prefetch next
    // WRITE   | pass write words to back-end
    // REGWR   | register write, single word at cycle 3, then ignore until csn rises

    localparam int DW = 2 * WIDTH;

    typedef enum logic [2:0] {IDLE, CA, LATENCY, READ, WRITE, REGWR} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [ADDR_LENGTH-1:0] addr_q, addr_d;
    logic [31:0]            ca_q, ca_d;
    logic                   rd_q, rd_d;
    logic                   as_q, as_d;
    logic [15:0]            rdat_q, rdat_d;

    logic                   step;
    logic                   dbl_lat;
    logic [15:0]            ca_word;
    logic [31:0]            ca_adr;
    logic [7:0]             lat_m1;
    logic [1:0]             rwds_ca;
    logic [15:0]            reg_word;
    logic                   unused_burst;

`ifdef HBUS_TARGET_REGS_EN
    logic [15:0] cr0_q, cr0_d;

    function automatic logic [15:0] reg_read(input logic [ADDR_LENGTH-1:0] a, input logic [15:0] cr0);
        logic [15:0] v;
        v = 16'h0000;
        if (a == ADDR_LENGTH'(0))
            v = ID0_VALUE;
        else if (a == ADDR_LENGTH'(1))
            v = ID1_VALUE;
        else if (a == ADDR_LENGTH'(32'h800))
            v = cr0;
        else if (a == ADDR_LENGTH'(32'h801))
            v = 16'h0001;
        return v;
    endfunction

    assign dbl_lat  = cr0_q[3];
    assign reg_word = reg_read(addr_q, cr0_q);
`else
    assign dbl_lat  = CR0_RESET[3];
    assign reg_word = 16'h0000;
`endif

    assign step         = ck_en & ~csn;
    assign ca_word      = dq_in[15:0];
    assign ca_adr       = {ca_q[28:0], ca_word[2:0]};
    assign lat_m1       = dbl_lat ? 8'(2 * LATENCY_COUNT - 1) : 8'(LATENCY_COUNT - 1);
    assign rwds_ca      = dbl_lat ? 2'b11 : 2'b00;
    // Wrapped bursts are served linearly, so the burst-type bit carries no meaning here.
    assign unused_burst = ca_q[29];

    always_ff @(posedge clk90 or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            ca_q    <= '0;
            rd_q    <= 1'b0;
            as_q    <= 1'b0;
            rdat_q  <= '0;
`ifdef HBUS_TARGET_REGS_EN
            cr0_q   <= CR0_RESET;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ca_q    <= ca_d;
            rd_q    <= rd_d;
            as_q    <= as_d;
            rdat_q  <= rdat_d;
`ifdef HBUS_TARGET_REGS_EN
            cr0_q   <= cr0_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        ca_d     = ca_q;
        rd_d     = rd_q;
        as_d     = as_q;
        rdat_d   = rdat_q;
`ifdef HBUS_TARGET_REGS_EN
        cr0_d    = cr0_q;
`endif
        dq_out   = '0;
        dq_oe    = 1'b0;
        rwds_out = 2'b00;
        rwds_oe  = 1'b0;
        mem_adr  = addr_q;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        mem_be   = 2'b00;
        mem_wdat = '0;

        case (state_q)
            IDLE: begin
                // Cycle 0 is spent in IDLE, so RWDS must already be driven here.
                if (!csn && !rst) begin
                    rwds_oe  = 1'b1;
                    rwds_out = rwds_ca;
                end
                if (step) begin
                    ca_d[31:16] = ca_word;
                    cnt_d       = 8'd1;
                    state_d     = CA;
                end
            end
            CA: begin
                rwds_oe  = 1'b1;
                rwds_out = rwds_ca;
                if (step) begin
                    if (cnt_q == 8'd1) begin
                        ca_d[15:0] = ca_word;
                        cnt_d      = 8'd2;
                    end else begin
                        rd_d   = ca_q[31];
                        as_d   = ca_q[30];
                        addr_d = ADDR_LENGTH'(ca_adr);
                        if (!ca_q[31] && ca_q[30]) begin
                            state_d = REGWR;
                            cnt_d   = '0;
                        end else begin
                            state_d = LATENCY;
                            cnt_d   = lat_m1;
                        end
                    end
                end
            end
            LATENCY: begin
                rwds_oe = rd_q;
                if (step) begin
                    if (cnt_q == '0) begin
                        state_d = rd_q ? READ : WRITE;
                        if (rd_q) begin
                            mem_re = ~as_q;
                            rdat_d = reg_word;
                            addr_d = addr_q + ADDR_LENGTH'(1);
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            READ: begin
                dq_oe    = 1'b1;
                rwds_oe  = 1'b1;
                rwds_out = 2'b10;
                dq_out   = as_q ? DW'(rdat_q) : mem_rdat;
                if (step) begin
                    mem_re = ~as_q;
                    rdat_d = reg_word;
                    addr_d = addr_q + ADDR_LENGTH'(1);
                end
            end
            WRITE: begin
                if (step) begin
                    mem_we   = (rwds_in != 2'b11);
                    mem_wdat = dq_in;
                    mem_be   = ~rwds_in;
                    addr_d   = addr_q + ADDR_LENGTH'(1);
                end
            end
            REGWR: begin
                if (step && cnt_q == '0) begin
                    cnt_d = 8'd1;
`ifdef HBUS_TARGET_REGS_EN
                    if (addr_q == ADDR_LENGTH'(32'h800))
                        cr0_d = dq_in[15:0];
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (csn)
            state_d = IDLE;
    end

endmodule
